// File: rtl/scrypt_scratchpad.sv
// Byte-addressable scratchpad returning one wide block per access from any byte address.
// Banked by address low bits so every byte lane has exactly one write and one read port.
module scrypt_scratchpad #(
    parameter int ADDR_BITS  = 17,
    parameter int DATA_WORDS = 128,
    parameter int WORD_BITS  = 8,
    parameter int ACC_BITS   = DATA_WORDS * WORD_BITS
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 r_enable,
    input  logic                 w_enable,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [ACC_BITS-1:0]  w_data,
    output logic [ACC_BITS-1:0]  r_data
);

    localparam int OFF_BITS = $clog2(DATA_WORDS);
    localparam int ROW_BITS = ADDR_BITS - OFF_BITS;
    localparam int ROWS     = 1 << ROW_BITS;

    logic [OFF_BITS-1:0] off;
    logic [ROW_BITS-1:0] row;
    logic [ROW_BITS-1:0] row_inc;
    logic                rd_go;
    logic                wr_go;

    logic                valid_q;
    logic                valid_d;
    logic [OFF_BITS-1:0] rd_off_q;
    logic [OFF_BITS-1:0] rd_off_d;

    logic [WORD_BITS-1:0] bank_rd [DATA_WORDS];

    assign off     = addr[OFF_BITS-1:0];
    assign row     = addr[ADDR_BITS-1:OFF_BITS];
    assign row_inc = row + ROW_BITS'(1);

    // Requests are qualified with n_rst because the array itself has no reset.
    assign rd_go = r_enable & n_rst;
    assign wr_go = w_enable & n_rst;

    // Bank b holds every address whose low bits equal b. Banks below the start offset
    // belong to the next row, which also yields the wrap from the top row back to row 0.
    for (genvar b = 0; b < DATA_WORDS; b++) begin : g_bank
        logic [WORD_BITS-1:0] bank_q [ROWS];
        logic [WORD_BITS-1:0] rd_q;
        logic [OFF_BITS-1:0]  lane;
        logic [ROW_BITS-1:0]  row_b;

        assign lane  = OFF_BITS'(b) - off;
        assign row_b = (OFF_BITS'(b) < off) ? row_inc : row;

        // Non-blocking read of bank_q gives read-first behaviour on a same-edge write.
        always_ff @(posedge clk) begin
            if (wr_go) begin
                bank_q[row_b] <= w_data[int'(lane)*WORD_BITS +: WORD_BITS];
            end
            if (rd_go) begin
                rd_q <= bank_q[row_b];
            end
        end

        assign bank_rd[b] = rd_q;
    end

    always_comb begin
        valid_d  = valid_q;
        rd_off_d = rd_off_q;
        if (rd_go) begin
            valid_d  = 1'b1;
            rd_off_d = off;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q  <= 1'b0;
            rd_off_q <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_off_q <= rd_off_d;
        end
    end

    // Rotate bank outputs back into access order; zero until a read lands after reset.
    always_comb begin
        logic [OFF_BITS-1:0] idx;
        r_data = '0;
        idx    = '0;
        if (valid_q) begin
            for (int k = 0; k < DATA_WORDS; k++) begin
                idx = OFF_BITS'(k) + rd_off_q;
                r_data[k*WORD_BITS +: WORD_BITS] = bank_rd[idx];
            end
        end
    end

endmodule

// File: tb/tb_scrypt_scratchpad.sv
// Directed bench for scrypt_scratchpad: reset, overlap, unaligned, read-first, wrap, reset drop.
module tb_scrypt_scratchpad;

    localparam int AB = 17;
    localparam int AW = 1024;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          r_enable;
    logic          w_enable;
    logic [AB-1:0] addr;
    logic [AW-1:0] w_data;
    logic [AW-1:0] r_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scrypt_scratchpad dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .r_enable (r_enable),
        .w_enable (w_enable),
        .addr     (addr),
        .w_data   (w_data),
        .r_data   (r_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        int first;
        first = 0;
        for (int k = 127; k >= 0; k--) begin
            if (obs[k*8 +: 8] !== exp[k*8 +: 8]) first = k;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s first bad byte %0d observed=%h expected=%h (low 64b observed=%h expected=%h)",
                   tag, first, obs[first*8 +: 8], exp[first*8 +: 8], obs[63:0], exp[63:0]);
        end
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic [AW-1:0] d);
        addr     = a;
        w_data   = d;
        w_enable = 1'b1;
        tick();
        w_enable = 1'b0;
    endtask

    task automatic rd(input logic [AB-1:0] a);
        addr     = a;
        r_enable = 1'b1;
        tick();
        r_enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] e;
        logic [AW-1:0] pat;

        n_rst    = 1'b0;
        r_enable = 1'b0;
        w_enable = 1'b0;
        addr     = '0;
        w_data   = '0;
        repeat (10) tick();
        check("reset_idle", r_data, '0);

        n_rst = 1'b1;
        tick();
        rd(17'd0);
        check("zero_init", r_data, '0);

        // mem[0..7]=FF, mem[8]=05, everything else zero
        wr(17'd0, '1);
        wr(17'd8, AW'(5));
        rd(17'd0);
        check("overlap_rd0", r_data, 1024'h05FFFFFFFFFFFFFFFF);
        rd(17'd1);
        check("unaligned_rd1", r_data, 1024'h05FFFFFFFFFFFFFF);

        addr     = 17'd16;
        w_data   = '1;
        r_enable = 1'b1;
        w_enable = 1'b1;
        tick();
        r_enable = 1'b0;
        w_enable = 1'b0;
        check("rw_read_first", r_data, '0);

        // mem[16..143] now FF
        rd(17'd16);
        check("rd16_after_rw", r_data, '1);

        rd(17'd2);
        e = '1;
        e[6*8 +: 8] = 8'h05;
        for (int k = 7; k <= 13; k++) e[k*8 +: 8] = 8'h00;
        check("merge_rd2", r_data, e);

        rd(17'd4);
        e = '1;
        e[4*8 +: 8] = 8'h05;
        for (int k = 5; k <= 11; k++) e[k*8 +: 8] = 8'h00;
        check("merge_rd4", r_data, e);

        rd(17'd8);
        e = '1;
        e[0 +: 8] = 8'h05;
        for (int k = 1; k <= 7; k++) e[k*8 +: 8] = 8'h00;
        check("merge_rd8", r_data, e);

        rd(17'd64);
        e = '0;
        for (int k = 0; k <= 79; k++) e[k*8 +: 8] = 8'hFF;
        check("merge_rd64", r_data, e);

        rd(17'd1024);
        check("far_rd1024", r_data, '0);

        for (int k = 0; k < 128; k++) pat[k*8 +: 8] = 8'(k);
        wr(17'h1FFF0, pat);
        rd(17'h1FFF0);
        check("wrap_rd_top", r_data, pat);

        addr   = 17'd5;
        w_data = '0;
        tick();
        check("hold_no_enable", r_data, pat);

        // wrap write covered mem[0..111] with 0x10..0x7F; mem[112..143] still FF
        rd(17'd0);
        e = '1;
        for (int k = 0; k <= 111; k++) e[k*8 +: 8] = 8'(k + 16);
        check("wrap_rd0", r_data, e);

        addr     = 17'h100;
        w_data   = '1;
        w_enable = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        check("reset_async_clear", r_data, '0);
        tick();
        tick();
        w_enable = 1'b0;
        check("reset_holds_zero", r_data, '0);
        n_rst = 1'b1;
        tick();

        rd(17'h100);
        check("reset_write_dropped", r_data, '0);

        rd(17'd16);
        e = '1;
        for (int k = 0; k <= 95; k++) e[k*8 +: 8] = 8'(k + 32);
        check("data_intact_rd16", r_data, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
